// File: rtl/nodf_status_pkg.sv
// nodf_status_pkg: state encoding and saturating-increment helper for the HLS status tracker.
package nodf_status_pkg;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_DONE_HOLD = 2'd2;
  localparam logic [1:0] ST_FINISHED  = 2'd3;
  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    RUN       = ST_RUN,
    DONE_HOLD = ST_DONE_HOLD,
    FINISHED  = ST_FINISHED
  } state_t;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v >= top) ? top : v + 64'd1;
  endfunction
endpackage

// File: rtl/nodf_module_status_tracker_sat_counter.sv
// sat_counter: saturating counter with synchronous clear (clear+inc loads 1) and freeze.
module sat_counter
  import nodf_status_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         freeze,
  input  logic         clear,
  output logic [W-1:0] cnt
);
  logic [W-1:0] base;
  assign base = clear ? '0 : cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (!freeze) cnt <= inc ? W'(sat_inc(64'(base), W)) : base;
endmodule

// File: rtl/nodf_module_status_tracker.sv
// nodf_module_status_tracker: passive ap_ctrl_hs observer with transaction counts and latency stats.
// Defining MODULE_STALL_COUNT_EN adds stall_cnt, the number of cycles spent in DONE_HOLD.
module nodf_module_status_tracker
  import nodf_status_pkg::*;
#(
  parameter int               CNT_W        = 32,
  parameter logic [CNT_W-1:0] LAT_INIT_MIN = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] cur_lat,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic             lat_valid
`ifdef MODULE_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  state_t st, nx;
  logic acc, cmp, fin, rec, cur_inc, cur_clr;
  logic [CNT_W-1:0] rec_lat;
  assign acc   = ap_start & ap_ready;
  assign cmp   = ap_done & ap_continue;
  assign fin   = st == FINISHED;
  assign state = st;
  assign busy  = st == RUN || st == DONE_HOLD;
  // A completion seen in IDLE together with its start is a combinational block: latency 1.
  assign rec_lat = (st == IDLE) ? CNT_W'(1) : CNT_W'(sat_inc(64'(cur_lat), CNT_W));
  always_comb begin
    nx      = st;
    rec     = 1'b0;
    cur_inc = 1'b0;
    cur_clr = 1'b0;
    case (st)
      IDLE: begin
        rec     = ap_start & cmp;
        nx      = (ap_start & !cmp) ? RUN : IDLE;
        cur_clr = ap_start;
        cur_inc = ap_start & !cmp;
      end
      RUN, DONE_HOLD: begin
        rec     = cmp;
        nx      = cmp ? (ap_start ? RUN : IDLE) : (ap_done ? DONE_HOLD : st);
        cur_clr = cmp;
        cur_inc = cmp ? ap_start : (st == RUN && !ap_done);
      end
      default: ;
    endcase
    if (finish) nx = FINISHED;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) st <= IDLE;
    else st <= nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      last_lat  <= '0;
      max_lat   <= '0;
      min_lat   <= LAT_INIT_MIN;
      lat_valid <= 1'b0;
    end else begin
      lat_valid <= rec;
      if (rec) begin
        last_lat <= rec_lat;
        max_lat  <= (rec_lat > max_lat) ? rec_lat : max_lat;
        min_lat  <= (rec_lat < min_lat) ? rec_lat : min_lat;
      end
    end
  sat_counter #(.W(CNT_W)) u_start (.clock(clock), .reset(reset), .inc(acc), .freeze(fin),
                                    .clear(1'b0), .cnt(start_cnt));
  sat_counter #(.W(CNT_W)) u_done (.clock(clock), .reset(reset), .inc(cmp), .freeze(fin),
                                   .clear(1'b0), .cnt(done_cnt));
  sat_counter #(.W(CNT_W)) u_cur (.clock(clock), .reset(reset), .inc(cur_inc), .freeze(fin),
                                  .clear(cur_clr), .cnt(cur_lat));
`ifdef MODULE_STALL_COUNT_EN
  sat_counter #(.W(CNT_W)) u_stall (.clock(clock), .reset(reset), .inc(st == DONE_HOLD),
                                    .freeze(fin), .clear(1'b0), .cnt(stall_cnt));
`endif
endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// tb_nodf_module_status_tracker: directed vectors with hand-computed expectations (8-bit counters).
module tb_nodf_module_status_tracker;
  logic clock = 1'b0, reset = 1'b1;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0, finish = 1'b0;
  logic [1:0] state;
  logic busy, lat_valid;
  logic [7:0] start_cnt, done_cnt, cur_lat, last_lat, max_lat, min_lat;
`ifdef MODULE_STALL_COUNT_EN
  logic [7:0] stall_cnt;
`endif
  int vectors = 0, miscompares = 0;
  int lats[3] = '{3, 7, 2};
  always #5 clock = ~clock;
  nodf_module_status_tracker #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .state(state), .busy(busy), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .cur_lat(cur_lat), .last_lat(last_lat), .max_lat(max_lat), .min_lat(min_lat),
    .lat_valid(lat_valid)
`ifdef MODULE_STALL_COUNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic s, input logic r, input logic d, input logic c);
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    finish = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    do_reset();
    repeat (10) step();
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_start", start_cnt, 0);
    check("rst_done", done_cnt, 0);
    check("rst_cur", cur_lat, 0);
    check("rst_last", last_lat, 0);
    check("rst_max", max_lat, 0);
    check("rst_min", min_lat, 8'hFF);
    check("rst_valid", lat_valid, 0);
    // single transaction, latency 5
    drive(1, 1, 0, 1);
    step();
    check("t1_state_run", state, 1);
    check("t1_cur", cur_lat, 1);
    check("t1_start", start_cnt, 1);
    drive(0, 0, 0, 1);
    repeat (3) step();
    check("t1_cur_mid", cur_lat, 4);
    drive(0, 0, 1, 1);
    step();
    check("t1_last", last_lat, 5);
    check("t1_max", max_lat, 5);
    check("t1_min", min_lat, 5);
    check("t1_done", done_cnt, 1);
    check("t1_valid", lat_valid, 1);
    check("t1_state_idle", state, 0);
    check("t1_cur_idle", cur_lat, 0);
    drive(0, 0, 0, 1);
    step();
    check("t1_valid_drop", lat_valid, 0);
    // spurious done while idle
    drive(0, 0, 1, 1);
    step();
    check("sp_done", done_cnt, 2);
    check("sp_last", last_lat, 5);
    check("sp_valid", lat_valid, 0);
    check("sp_state", state, 0);
    // combinational block: start and done together in IDLE
    drive(1, 1, 1, 1);
    step();
    check("cb_last", last_lat, 1);
    check("cb_min", min_lat, 1);
    check("cb_state", state, 0);
    check("cb_start", start_cnt, 2);
    // back-to-back latencies 3, 7, 2
    do_reset();
    drive(1, 1, 0, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      repeat (lats[i] - 2) begin
        step();
        check("b2b_busy", busy, 1);
      end
      drive(i < 2, i < 2, 1, 1);
      step();
      check("b2b_last", last_lat, lats[i]);
      check("b2b_state", state, (i < 2) ? 1 : 0);
    end
    check("b2b_done", done_cnt, 3);
    check("b2b_start", start_cnt, 3);
    check("b2b_max", max_lat, 7);
    check("b2b_min", min_lat, 2);
    // done held against back-pressure for 4 cycles
    do_reset();
    drive(1, 1, 0, 0);
    step();
    drive(0, 0, 0, 0);
    repeat (2) step();
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_state", state, 2);
      check("hold_cur", cur_lat, 3);
    end
    drive(0, 0, 1, 1);
    step();
    check("hold_last", last_lat, 4);
    check("hold_valid", lat_valid, 1);
    check("hold_done", done_cnt, 1);
    check("hold_exit", state, 0);
`ifdef MODULE_STALL_COUNT_EN
    check("hold_stall", stall_cnt, 4);
`endif
    // finish mid-run freezes everything
    do_reset();
    drive(1, 1, 0, 1);
    step();
    drive(0, 0, 0, 1);
    repeat (2) step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    check("fin_state", state, 3);
    for (int i = 0; i < 6; i++) begin
      drive(i[0], i[0], ~i[0], 1);
      step();
    end
    check("fin_state_hold", state, 3);
    check("fin_start", start_cnt, 1);
    check("fin_done", done_cnt, 0);
    check("fin_last", last_lat, 0);
    check("fin_valid", lat_valid, 0);
    check("fin_busy", busy, 0);
    do_reset();
    check("fin_reset_state", state, 0);
    check("fin_reset_start", start_cnt, 0);
    // start_cnt saturation
    drive(1, 1, 0, 0);
    repeat (254) step();
    check("sat_pre", start_cnt, 8'hFE);
    repeat (3) step();
    check("sat_hold", start_cnt, 8'hFF);
    drive(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
